// File: rtl/stopwatch_core.sv
// Stopwatch control core: button FSM, DIGITS-wide BCD up/down counter, lap freeze, wrap/saturate limits.
// Optional clear button C is enabled by defining STOPWATCH_CLEAR_BTN_EN.
module stopwatch_core #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                U,
    input  logic                S,
    input  logic                D,
    input  logic                L,
`ifdef STOPWATCH_CLEAR_BTN_EN
    input  logic                C,
`endif
    output logic                count_up,
    output logic                paused,
    output logic                lap_hold,
    output logic                at_limit,
    output logic [4*DIGITS-1:0] value,
    output logic [4*DIGITS-1:0] disp
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM_S    = 3'd1,
        ARM_U    = 3'd2,
        ARM_D    = 3'd3,
        ARM_L    = 3'd4,
        WAIT_REL = 3'd5
`ifdef STOPWATCH_CLEAR_BTN_EN
        , ARM_C  = 3'd6
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          count_up_q, count_up_d;
    logic          paused_q, paused_d;
    logic          lap_hold_q, lap_hold_d;
    logic          at_limit_q, at_limit_d;
    logic [W-1:0]  value_q, value_d;
    logic [W-1:0]  lap_q, lap_d;
    logic          any_btn;
    logic          commit_s, commit_u, commit_d, commit_l;
`ifdef STOPWATCH_CLEAR_BTN_EN
    logic          commit_c;
`endif

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Out-of-range digits are forced to 9 so the result is always valid BCD.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else if (v[4*i +: 4] > 4'd9) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] nines();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

`ifdef STOPWATCH_CLEAR_BTN_EN
    assign any_btn = U | S | D | L | C;
`else
    assign any_btn = U | S | D | L;
`endif

    // An action commits in the cycle its ARM state sees the button released.
    always_comb begin
        state_d  = state_q;
        commit_s = 1'b0;
        commit_u = 1'b0;
        commit_d = 1'b0;
        commit_l = 1'b0;
`ifdef STOPWATCH_CLEAR_BTN_EN
        commit_c = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (S)      state_d = ARM_S;
                else if (U) state_d = ARM_U;
                else if (D) state_d = ARM_D;
                else if (L) state_d = ARM_L;
`ifdef STOPWATCH_CLEAR_BTN_EN
                else if (C) state_d = ARM_C;
`endif
            end
            ARM_S: if (!S) begin commit_s = 1'b1; state_d = any_btn ? WAIT_REL : IDLE; end
            ARM_U: if (!U) begin commit_u = 1'b1; state_d = any_btn ? WAIT_REL : IDLE; end
            ARM_D: if (!D) begin commit_d = 1'b1; state_d = any_btn ? WAIT_REL : IDLE; end
            ARM_L: if (!L) begin commit_l = 1'b1; state_d = any_btn ? WAIT_REL : IDLE; end
`ifdef STOPWATCH_CLEAR_BTN_EN
            ARM_C: if (!C) begin commit_c = 1'b1; state_d = any_btn ? WAIT_REL : IDLE; end
`endif
            WAIT_REL: if (!any_btn) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        count_up_d = count_up_q;
        paused_d   = paused_q;
        lap_hold_d = lap_hold_q;
        lap_d      = lap_q;
        value_d    = value_q;
        at_limit_d = WRAP ? 1'b0 : at_limit_q;

        if (commit_s) begin
            paused_d   = ~paused_q;
            at_limit_d = 1'b0;
        end
        if (commit_u) begin
            count_up_d = 1'b1;
            if (!count_up_q) at_limit_d = 1'b0;
        end
        if (commit_d) begin
            count_up_d = 1'b0;
            if (count_up_q) at_limit_d = 1'b0;
        end
        if (commit_l) begin
            lap_hold_d = ~lap_hold_q;
            if (!lap_hold_q) lap_d = value_q;
        end
`ifdef STOPWATCH_CLEAR_BTN_EN
        if (commit_c && paused_q) begin
            value_d    = '0;
            lap_d      = '0;
            lap_hold_d = 1'b0;
            at_limit_d = 1'b0;
        end
`endif

        // Counting uses the registered mode, so it is evaluated after the actions and overrides them.
        if (tick && !paused_q) begin
            if (count_up_q) begin
                if (all_nines(value_q)) begin
                    at_limit_d = 1'b1;
                    if (WRAP) value_d = '0;
                    else      paused_d = 1'b1;
                end else begin
                    value_d = bcd_inc(value_q);
                end
            end else begin
                if (value_q == '0) begin
                    at_limit_d = 1'b1;
                    if (WRAP) value_d = nines();
                    else      paused_d = 1'b1;
                end else begin
                    value_d = bcd_dec(value_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= any_btn ? WAIT_REL : IDLE;
            count_up_q <= 1'b1;
            paused_q   <= 1'b0;
            lap_hold_q <= 1'b0;
            at_limit_q <= 1'b0;
            value_q    <= '0;
            lap_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_up_q <= count_up_d;
            paused_q   <= paused_d;
            lap_hold_q <= lap_hold_d;
            at_limit_q <= at_limit_d;
            value_q    <= value_d;
            lap_q      <= lap_d;
        end
    end

    assign count_up = count_up_q;
    assign paused   = paused_q;
    assign lap_hold = lap_hold_q;
    assign at_limit = at_limit_q;
    assign value    = value_q;
    assign disp     = lap_hold_q ? lap_q : value_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a 4-digit wrapping instance and a 2-digit saturating instance.
module tb_stopwatch_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, tick_a = 1'b0, u_a = 1'b0, s_a = 1'b0, d_a = 1'b0, l_a = 1'b0, c_a = 1'b0;
    logic count_up_a, paused_a, lap_hold_a, at_limit_a;
    logic [15:0] value_a, disp_a;

    logic rst_b = 1'b1, tick_b = 1'b0, u_b = 1'b0, s_b = 1'b0, d_b = 1'b0, l_b = 1'b0, c_b = 1'b0;
    logic count_up_b, paused_b, lap_hold_b, at_limit_b;
    logic [7:0] value_b, disp_b;

    stopwatch_core #(.DIGITS(4), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .tick(tick_a), .U(u_a), .S(s_a), .D(d_a), .L(l_a),
`ifdef STOPWATCH_CLEAR_BTN_EN
        .C(c_a),
`endif
        .count_up(count_up_a), .paused(paused_a), .lap_hold(lap_hold_a),
        .at_limit(at_limit_a), .value(value_a), .disp(disp_a)
    );

    stopwatch_core #(.DIGITS(2), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .tick(tick_b), .U(u_b), .S(s_b), .D(d_b), .L(l_b),
`ifdef STOPWATCH_CLEAR_BTN_EN
        .C(c_b),
`endif
        .count_up(count_up_b), .paused(paused_b), .lap_hold(lap_hold_b),
        .at_limit(at_limit_b), .value(value_b), .disp(disp_b)
    );

    localparam int SEL_VAL_A = 0, SEL_DISP_A = 1, SEL_UP_A = 2, SEL_PAUSE_A = 3,
                   SEL_LAP_A = 4, SEL_LIM_A = 5, SEL_VAL_B = 6, SEL_UP_B = 7,
                   SEL_PAUSE_B = 8, SEL_LIM_B = 9;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_VAL_A:   return {16'h0, value_a};
            SEL_DISP_A:  return {16'h0, disp_a};
            SEL_UP_A:    return {31'h0, count_up_a};
            SEL_PAUSE_A: return {31'h0, paused_a};
            SEL_LAP_A:   return {31'h0, lap_hold_a};
            SEL_LIM_A:   return {31'h0, at_limit_a};
            SEL_VAL_B:   return {24'h0, value_b};
            SEL_UP_B:    return {31'h0, count_up_b};
            SEL_PAUSE_B: return {31'h0, paused_b};
            SEL_LIM_B:   return {31'h0, at_limit_b};
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Expectations queued before a step describe the outputs after that clock edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        // Reset of the wrapping instance
        push_exp("rst_value", SEL_VAL_A, 32'h0);
        push_exp("rst_disp", SEL_DISP_A, 32'h0);
        push_exp("rst_count_up", SEL_UP_A, 32'h1);
        push_exp("rst_paused", SEL_PAUSE_A, 32'h0);
        push_exp("rst_lap_hold", SEL_LAP_A, 32'h0);
        push_exp("rst_at_limit", SEL_LIM_A, 32'h0);
        step();
        rst_a = 1'b0;
        step();

        tick_a = 1'b1;
        steps(12);
        tick_a = 1'b0;
        push_exp("up12_value", SEL_VAL_A, 32'h0012);
        push_exp("up12_disp", SEL_DISP_A, 32'h0012);
        push_exp("up12_count_up", SEL_UP_A, 32'h1);
        push_exp("up12_paused", SEL_PAUSE_A, 32'h0);
        step();

        // D held during ticks keeps counting up; release switches direction
        d_a = 1'b1;
        step();
        tick_a = 1'b1;
        steps(3);
        tick_a = 1'b0;
        push_exp("dheld_value", SEL_VAL_A, 32'h0015);
        push_exp("dheld_count_up", SEL_UP_A, 32'h1);
        step();
        d_a = 1'b0;
        push_exp("drel_count_up", SEL_UP_A, 32'h0);
        push_exp("drel_value", SEL_VAL_A, 32'h0015);
        step();
        tick_a = 1'b1;
        steps(2);
        tick_a = 1'b0;
        push_exp("down2_value", SEL_VAL_A, 32'h0013);
        step();

        // Down through zero wraps to all nines with a one-cycle flag
        tick_a = 1'b1;
        steps(13);
        tick_a = 1'b0;
        push_exp("down_zero_value", SEL_VAL_A, 32'h0000);
        push_exp("down_zero_limit", SEL_LIM_A, 32'h0);
        step();
        tick_a = 1'b1;
        push_exp("wrap_dn_value", SEL_VAL_A, 32'h9999);
        push_exp("wrap_dn_limit", SEL_LIM_A, 32'h1);
        step();
        tick_a = 1'b0;
        push_exp("wrap_dn_pulse_end", SEL_LIM_A, 32'h0);
        push_exp("wrap_dn_hold", SEL_VAL_A, 32'h9999);
        step();

        // Back to up, wrap all nines to zero
        u_a = 1'b1;
        step();
        u_a = 1'b0;
        push_exp("urel_count_up", SEL_UP_A, 32'h1);
        step();
        tick_a = 1'b1;
        push_exp("wrap_up_value", SEL_VAL_A, 32'h0000);
        push_exp("wrap_up_limit", SEL_LIM_A, 32'h1);
        step();
        tick_a = 1'b0;
        push_exp("wrap_up_pulse_end", SEL_LIM_A, 32'h0);
        step();

        // Lap freeze
        tick_a = 1'b1;
        steps(40);
        tick_a = 1'b0;
        push_exp("pre_lap_value", SEL_VAL_A, 32'h0040);
        step();
        l_a = 1'b1;
        step();
        l_a = 1'b0;
        push_exp("lap_on", SEL_LAP_A, 32'h1);
        push_exp("lap_on_disp", SEL_DISP_A, 32'h0040);
        step();
        tick_a = 1'b1;
        steps(5);
        tick_a = 1'b0;
        push_exp("lap_live_value", SEL_VAL_A, 32'h0045);
        push_exp("lap_frozen_disp", SEL_DISP_A, 32'h0040);
        step();
        l_a = 1'b1;
        step();
        l_a = 1'b0;
        push_exp("lap_off", SEL_LAP_A, 32'h0);
        push_exp("lap_off_disp", SEL_DISP_A, 32'h0045);
        step();

        // Tick in the S commit cycle still counts with the old running mode
        s_a = 1'b1;
        step();
        s_a = 1'b0;
        tick_a = 1'b1;
        push_exp("scol_value", SEL_VAL_A, 32'h0046);
        push_exp("scol_paused", SEL_PAUSE_A, 32'h1);
        step();
        push_exp("paused_tick_value", SEL_VAL_A, 32'h0046);
        step();
        tick_a = 1'b0;

        // S has priority over D; D release while armed on S is ignored
        s_a = 1'b1;
        d_a = 1'b1;
        step();
        d_a = 1'b0;
        step();
        s_a = 1'b0;
        push_exp("prio_paused", SEL_PAUSE_A, 32'h0);
        push_exp("prio_count_up", SEL_UP_A, 32'h1);
        step();

        // After a commit with another button held, that button's release does nothing
        s_a = 1'b1;
        d_a = 1'b1;
        step();
        s_a = 1'b0;
        push_exp("waitrel_paused", SEL_PAUSE_A, 32'h1);
        step();
        d_a = 1'b0;
        push_exp("waitrel_count_up", SEL_UP_A, 32'h1);
        push_exp("waitrel_paused2", SEL_PAUSE_A, 32'h1);
        step();

        // Reset while S is held: the S release must not toggle
        s_a = 1'b1;
        rst_a = 1'b1;
        push_exp("rst_s_paused", SEL_PAUSE_A, 32'h0);
        push_exp("rst_s_value", SEL_VAL_A, 32'h0);
        step();
        rst_a = 1'b0;
        step();
        s_a = 1'b0;
        push_exp("rst_s_rel_paused", SEL_PAUSE_A, 32'h0);
        step();
        push_exp("rst_s_idle_paused", SEL_PAUSE_A, 32'h0);
        step();
        s_a = 1'b1;
        step();
        s_a = 1'b0;
        push_exp("rst_s_next_press", SEL_PAUSE_A, 32'h1);
        step();

`ifdef STOPWATCH_CLEAR_BTN_EN
        s_a = 1'b1;
        step();
        s_a = 1'b0;
        step();
        tick_a = 1'b1;
        steps(123);
        tick_a = 1'b0;
        s_a = 1'b1;
        step();
        s_a = 1'b0;
        push_exp("clr_pre_paused", SEL_PAUSE_A, 32'h1);
        push_exp("clr_pre_value", SEL_VAL_A, 32'h0123);
        step();
        c_a = 1'b1;
        step();
        c_a = 1'b0;
        push_exp("clr_value", SEL_VAL_A, 32'h0);
        push_exp("clr_count_up", SEL_UP_A, 32'h1);
        step();
`endif

        // Saturating 2-digit instance
        rst_b = 1'b0;
        step();
        tick_b = 1'b1;
        steps(98);
        tick_b = 1'b0;
        push_exp("b_value98", SEL_VAL_B, 32'h98);
        step();
        tick_b = 1'b1;
        push_exp("b_value99", SEL_VAL_B, 32'h99);
        push_exp("b_value99_paused", SEL_PAUSE_B, 32'h0);
        push_exp("b_value99_limit", SEL_LIM_B, 32'h0);
        step();
        push_exp("b_sat_value", SEL_VAL_B, 32'h99);
        push_exp("b_sat_paused", SEL_PAUSE_B, 32'h1);
        push_exp("b_sat_limit", SEL_LIM_B, 32'h1);
        step();
        tick_b = 1'b0;
        push_exp("b_sat_latched", SEL_LIM_B, 32'h1);
        step();
        s_b = 1'b1;
        step();
        s_b = 1'b0;
        push_exp("b_resume_paused", SEL_PAUSE_B, 32'h0);
        push_exp("b_resume_limit", SEL_LIM_B, 32'h0);
        step();
        d_b = 1'b1;
        step();
        d_b = 1'b0;
        push_exp("b_down_count_up", SEL_UP_B, 32'h0);
        step();
        tick_b = 1'b1;
        steps(99);
        push_exp("b_zero_sat_value", SEL_VAL_B, 32'h00);
        push_exp("b_zero_sat_paused", SEL_PAUSE_B, 32'h1);
        push_exp("b_zero_sat_limit", SEL_LIM_B, 32'h1);
        step();
        tick_b = 1'b0;
        s_b = 1'b1;
        step();
        s_b = 1'b0;
        push_exp("b_resume2_paused", SEL_PAUSE_B, 32'h0);
        push_exp("b_resume2_limit", SEL_LIM_B, 32'h0);
        step();
        s_b = 1'b1;
        step();
        s_b = 1'b0;
        tick_b = 1'b1;
        push_exp("b_satcol_value", SEL_VAL_B, 32'h00);
        push_exp("b_satcol_paused", SEL_PAUSE_B, 32'h1);
        push_exp("b_satcol_limit", SEL_LIM_B, 32'h1);
        step();
        tick_b = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
